// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared constants and types for the BitCruncher microprogrammed control unit
package cu_pkg;

  localparam int CAR_W          = 8;
  localparam int CW_W           = 32;
  localparam int CTL_W          = 22;
  localparam int ROUTINE_STRIDE = 8;

  localparam logic [CAR_W-1:0] FETCH0        = 8'h00;
  localparam logic [CAR_W-1:0] DISPATCH_BASE = 8'h10;

  // Control-word bit positions
  localparam int C_CAR_INC  = 0;
  localparam int C_REDIRECT = 1;
  localparam int C_CAR_ZERO = 2;
  localparam int C_MBR_MEM  = 3;
  localparam int C_IR_MBR   = 4;
  localparam int C_MAR_MBR  = 5;
  localparam int C_PC_INC   = 6;
  localparam int C_BR_MBR   = 7;
  localparam int C_ACC_CLR  = 8;
  localparam int C_ACC_ADD  = 9;
  localparam int C_MAR_PC   = 10;
  localparam int C_MEM_MBR  = 11;
  localparam int C_MBR_ACC  = 12;
  localparam int C_ACC_SUB  = 13;
  localparam int C_PC_MBR   = 14;
  localparam int C_ACC_MUL  = 15;
  localparam int C_ACC_DIV  = 16;
  localparam int C_ACC_SHL  = 17;
  localparam int C_ACC_SHR  = 18;
  localparam int C_ACC_AND  = 19;
  localparam int C_ACC_OR   = 20;
  localparam int C_ACC_NOT  = 21;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_STORE  = 4'h1,
    OP_LOAD   = 4'h2,
    OP_ADD    = 4'h3,
    OP_SUB    = 4'h4,
    OP_JMPGEZ = 4'h5,
    OP_JMP    = 4'h6,
    OP_HALT   = 4'h7,
    OP_MPY    = 4'h8,
    OP_DIV    = 4'h9,
    OP_AND    = 4'hA,
    OP_OR     = 4'hB,
    OP_NOT    = 4'hC,
    OP_SHIFTR = 4'hD,
    OP_SHIFTL = 4'hE,
    OP_NOP_F  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    COND_NONE     = 2'b00,
    COND_SF_CLEAR = 2'b01
  } cond_e;

  typedef struct packed {
    cond_e            cond;
    logic [CTL_W-1:0] ctl;
  } rom_word_t;

  function automatic logic [CTL_W-1:0] cbit(input int idx);
    cbit      = '0;
    cbit[idx] = 1'b1;
  endfunction

  function automatic logic [CAR_W-1:0] routine_base(input logic [3:0] op);
    return DISPATCH_BASE + CAR_W'(ROUTINE_STRIDE) * {4'b0000, op};
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - opcode/flags in, control word out between datapath and control unit
interface control_unit_if;
  import cu_pkg::*;

  logic [7:0]      IR_in;
  logic [3:0]      ALUflags;
  logic [CW_W-1:0] Control_Signals;

  modport master (output IR_in, output ALUflags, input  Control_Signals);
  modport slave  (input  IR_in, input  ALUflags, output Control_Signals);
endinterface

// File: rtl/cu_microrom.sv
// rtl/cu_microrom.sv - combinational 256x24 microprogram ROM
module cu_microrom
  import cu_pkg::*;
(
  input  logic [CAR_W-1:0] addr,
  output rom_word_t        word
);

  logic [CAR_W-1:0] rel;
  logic [3:0]       op;
  logic [2:0]       step;
  logic             in_routines;
  logic [CTL_W-1:0] of_word;
  logic [CTL_W-1:0] alu_bit;

  // Routine area 0x10..0x8F: rel[7] is set for every address outside it
  assign rel         = addr - DISPATCH_BASE;
  assign op          = rel[6:3];
  assign step        = rel[2:0];
  assign in_routines = ~rel[7];

  always_comb begin
    of_word = '0;
    case (step)
      3'd0:    of_word = cbit(C_MAR_MBR) | cbit(C_CAR_INC);
      3'd1:    of_word = cbit(C_MBR_MEM) | cbit(C_CAR_INC);
      3'd2:    of_word = cbit(C_BR_MBR)  | cbit(C_CAR_INC);
      default: of_word = '0;
    endcase
  end

  always_comb begin
    alu_bit = '0;
    case (opcode_e'(op))
      OP_ADD:    alu_bit = cbit(C_ACC_ADD);
      OP_SUB:    alu_bit = cbit(C_ACC_SUB);
      OP_MPY:    alu_bit = cbit(C_ACC_MUL);
      OP_DIV:    alu_bit = cbit(C_ACC_DIV);
      OP_AND:    alu_bit = cbit(C_ACC_AND);
      OP_OR:     alu_bit = cbit(C_ACC_OR);
      OP_NOT:    alu_bit = cbit(C_ACC_NOT);
      OP_SHIFTR: alu_bit = cbit(C_ACC_SHR);
      OP_SHIFTL: alu_bit = cbit(C_ACC_SHL);
      default:   alu_bit = '0;
    endcase
  end

  // Anything not explicitly programmed returns to fetch
  always_comb begin
    word.cond = COND_NONE;
    word.ctl  = cbit(C_CAR_ZERO);
    if (addr == FETCH0) begin
      word.ctl = cbit(C_MAR_PC) | cbit(C_CAR_INC);
    end else if (addr == FETCH0 + 8'd1) begin
      word.ctl = cbit(C_MBR_MEM) | cbit(C_PC_INC) | cbit(C_CAR_INC);
    end else if (addr == FETCH0 + 8'd2) begin
      word.ctl = cbit(C_IR_MBR) | cbit(C_REDIRECT);
    end else if (in_routines) begin
      case (opcode_e'(op))
        OP_STORE: begin
          if (step == 3'd0)      word.ctl = cbit(C_MAR_MBR) | cbit(C_CAR_INC);
          else if (step == 3'd1) word.ctl = cbit(C_MBR_ACC) | cbit(C_CAR_INC);
          else if (step == 3'd2) word.ctl = cbit(C_MEM_MBR) | cbit(C_CAR_ZERO);
        end
        OP_LOAD: begin
          if (step < 3'd3)       word.ctl = of_word;
          else if (step == 3'd3) word.ctl = cbit(C_ACC_CLR) | cbit(C_CAR_INC);
          else if (step == 3'd4) word.ctl = cbit(C_ACC_ADD) | cbit(C_CAR_ZERO);
        end
        OP_JMPGEZ: begin
          if (step == 3'd0) begin
            word.cond = COND_SF_CLEAR;
            word.ctl  = cbit(C_PC_MBR) | cbit(C_CAR_ZERO);
          end
        end
        OP_JMP: begin
          if (step == 3'd0) word.ctl = cbit(C_PC_MBR) | cbit(C_CAR_ZERO);
        end
        OP_HALT: begin
          if (step == 3'd0) word.ctl = '0;
        end
        OP_ADD, OP_SUB, OP_MPY, OP_DIV, OP_AND, OP_OR, OP_NOT, OP_SHIFTR, OP_SHIFTL: begin
          if (step < 3'd3)       word.ctl = of_word;
          else if (step == 3'd3) word.ctl = alu_bit | cbit(C_CAR_ZERO);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - microprogrammed control unit: CAR, next-address logic, condition gating
module control_unit
  import cu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  control_unit_if.slave  bus
);

  logic [CAR_W-1:0] car;
  logic [CAR_W-1:0] car_next;
  rom_word_t        word;
  logic [CTL_W-1:0] ctl;
  logic             unused_flags;

  cu_microrom u_rom (
    .addr (car),
    .word (word)
  );

  // Only the sign flag is consulted; ZF/CF/OF are routed here for future conditions
  assign unused_flags = ^bus.ALUflags[3:1];

  always_comb begin
    ctl = word.ctl;
    if (word.cond == COND_SF_CLEAR && bus.ALUflags[0]) ctl[C_PC_MBR] = 1'b0;
  end

  assign bus.Control_Signals = {{(CW_W-CTL_W){1'b0}}, ctl};

  always_comb begin
    car_next = car;
    if (ctl[C_CAR_ZERO]) begin
      car_next = FETCH0;
    end else if (ctl[C_REDIRECT]) begin
      car_next = (bus.IR_in[7:4] == 4'h0) ? routine_base(bus.IR_in[3:0]) : routine_base(OP_NOP);
    end else if (ctl[C_CAR_INC]) begin
      car_next = car + 8'd1;
    end
  end

  // rst_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (rst_n) car <= FETCH0;
    else       car <= car_next;
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized self-checking bench for control_unit against an instruction-level model
module tb_control_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] exp_q[$];
  bit          cond_q[$];

  control_unit_if bus ();

  control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, input bit c);
    exp_q.push_back(w);
    cond_q.push_back(c);
  endtask

  // Expected control-word sequence of one whole instruction, from the bit map
  task automatic build_expected(input logic [7:0] ir);
    logic [3:0] op;
    exp_q.delete();
    cond_q.delete();
    op = (ir[7:4] != 4'h0) ? 4'h0 : ir[3:0];
    push(32'h401, 0); push(32'h049, 0); push(32'h012, 0);
    if (op inside {4'h2, 4'h3, 4'h4, [4'h8:4'hE]}) begin
      push(32'h021, 0); push(32'h009, 0); push(32'h081, 0);
    end
    case (op)
      4'h1: begin push(32'h021, 0); push(32'h1001, 0); push(32'h804, 0); end
      4'h2: begin push(32'h101, 0); push(32'h204, 0); end
      4'h3: push(32'h204, 0);
      4'h4: push(32'h2004, 0);
      4'h5: push(32'h4004, 1);
      4'h6: push(32'h4004, 0);
      4'h7: push(32'h0, 0);
      4'h8: push(32'h8004, 0);
      4'h9: push(32'h10004, 0);
      4'hA: push(32'h80004, 0);
      4'hB: push(32'h100004, 0);
      4'hC: push(32'h200004, 0);
      4'hD: push(32'h40004, 0);
      4'hE: push(32'h20004, 0);
      default: push(32'h4, 0);
    endcase
  endtask

  // Enters with CAR at fetch (reset may still be asserted); flags_mode<0 randomizes flags each cycle
  task automatic run_instr(input logic [7:0] ir, input int flags_mode, input int abort_at);
    logic [31:0] flags;
    logic [31:0] exp;
    bit          halted;
    build_expected(ir);
    halted = (ir[7:4] == 4'h0) && (ir[3:0] == 4'h7);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        rst_n     = 1'b0;
        bus.IR_in = ir;
      end else if (i >= 3) begin
        bus.IR_in = 8'($urandom);
      end
      flags        = (flags_mode < 0) ? $urandom : 32'(flags_mode);
      bus.ALUflags = flags[3:0];
      #1;
      exp = exp_q[i];
      if (cond_q[i] && flags[0]) exp = exp & ~32'h4000;
      check_eq($sformatf("ir%02h_w%0d", ir, i), bus.Control_Signals, exp);
      if (i == abort_at) begin
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_eq($sformatf("ir%02h_rst_mid", ir), bus.Control_Signals, 32'h401);
        return;
      end
    end
    if (halted) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        bus.IR_in    = 8'($urandom);
        bus.ALUflags = 4'($urandom);
        #1;
        check_eq($sformatf("halt_hold%0d", k), bus.Control_Signals, 32'h0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check_eq("halt_rst", bus.Control_Signals, 32'h401);
    end
  endtask

  initial begin
    logic [7:0] ir;
    int         ab;
    rst_n        = 1'b1;
    bus.IR_in    = 8'h00;
    bus.ALUflags = 4'h0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check_eq("reset", bus.Control_Signals, 32'h401);
    end

    run_instr(8'h02, -1, -1);
    run_instr(8'h03, -1, -1);
    run_instr(8'h05, 0, -1);
    run_instr(8'h05, 1, -1);
    run_instr(8'h0A, -1, -1);
    run_instr(8'h0B, -1, -1);
    run_instr(8'h0D, -1, -1);
    run_instr(8'h0E, -1, -1);
    run_instr(8'h07, -1, -1);
    run_instr(8'hFF, -1, -1);
    run_instr(8'h00, -1, -1);
    run_instr(8'h02, -1, 5);
    run_instr(8'h01, -1, -1);

    for (int n = 0; n < 200; n++) begin
      ir = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
      run_instr(ir, -1, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
